// File: rtl/max_tree_ctrl_if.sv
// max_tree_ctrl_if: row handshake for max_tree_ctrl; byp_* exist only with MAX_TREE_CTRL_BYPASS_EN
interface max_tree_ctrl_if #(parameter int N = 8, parameter int LEN_W = 10);
  logic             start;
  logic [LEN_W-1:0] row_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [N*16-1:0]  in_data;
  logic             max_valid;
  logic [15:0]      row_max;
`ifdef MAX_TREE_CTRL_BYPASS_EN
  logic [N-1:0]     byp_valid;
  logic [N*16-1:0]  byp_data;
`endif
  modport master (
    output start, row_len, in_valid, in_data,
    input  busy, in_ready, max_valid, row_max
`ifdef MAX_TREE_CTRL_BYPASS_EN
    , input byp_valid, byp_data
`endif
  );
  modport slave (
    input  start, row_len, in_valid, in_data,
    output busy, in_ready, max_valid, row_max
`ifdef MAX_TREE_CTRL_BYPASS_EN
    , output byp_valid, byp_data
`endif
  );
endinterface

// File: rtl/max_tree_ctrl.sv
// max_tree_ctrl: streams a row through a pipelined N-lane max tree and folds a running row max.
// Optional MAX_TREE_CTRL_BYPASS_EN adds byp_valid/byp_data aligned with each chunk's tree result.
module max_tree #(parameter int N = 8) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    valid_in,
  input  logic [N*16-1:0] data_in,
  output logic [15:0]     max_out,
  output logic            valid_max_out
`ifdef MAX_TREE_CTRL_BYPASS_EN
  , output logic [N*16-1:0] byp_data
`endif
);
  // heap layout: leaves N..2N-1, node i fed by 2i and 2i+1, one register per node
  logic [15:0] nd [1:2*N-1];
  logic        nv [1:2*N-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 2*N; i++) begin
        nd[i] <= '0;
        nv[i] <= 1'b0;
      end
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        nd[N+i] <= data_in[i*16+:16];
        nv[N+i] <= valid_in[i];
      end
      for (int i = 1; i < N; i++) begin
        nd[i] <= $signed(nd[2*i]) > $signed(nd[2*i+1]) ? nd[2*i] : nd[2*i+1];
        nv[i] <= nv[2*i] & nv[2*i+1];
      end
    end
  end
  assign max_out = nd[1];
  assign valid_max_out = nv[1];
`ifdef MAX_TREE_CTRL_BYPASS_EN
  localparam int S = $clog2(N);
  logic [N*16-1:0] bd [0:S];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) bd[k] <= '0;
    end else if (en) begin
      bd[0] <= data_in;
      for (int k = 1; k <= S; k++) bd[k] <= bd[k-1];
    end
  end
  assign byp_data = bd[S];
`endif
endmodule

module max_tree_ctrl #(parameter int N = 8, parameter int LEN_W = 10) (
  input logic clk,
  input logic rst,
  max_tree_ctrl_if.slave io
);
  localparam int S = $clog2(N);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t           state;
  logic [LEN_W-1:0] cnum, iss, ret;
  logic [S-1:0]     rem;
  logic             busy, in_ready, max_valid;
  logic [15:0]      row_max;
  logic             acc, last, tmax_v;
  logic [15:0]      tmax;
  logic [N-1:0]     pad;
  logic [N*16-1:0]  tdata;
  assign acc = in_ready & io.in_valid;
  assign last = iss == cnum - 1'b1;
  // 16'h8000 is the most negative Q6.10 value, so padded lanes never win a compare
  always_comb begin
    pad = '0;
    tdata = io.in_data;
    for (int i = 0; i < N; i++) begin
      pad[i] = last && rem != '0 && S'(i) >= rem;
      tdata[i*16+:16] = pad[i] ? 16'h8000 : io.in_data[i*16+:16];
    end
  end
  max_tree #(.N(N)) u_tree (
    .clk(clk),
    .rst(rst),
    .en(1'b1),
    .valid_in({N{acc}}),
    .data_in(tdata),
    .max_out(tmax),
    .valid_max_out(tmax_v)
`ifdef MAX_TREE_CTRL_BYPASS_EN
    , .byp_data(io.byp_data)
`endif
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnum <= '0;
      iss <= '0;
      ret <= '0;
      rem <= '0;
      busy <= 1'b0;
      in_ready <= 1'b0;
      max_valid <= 1'b0;
      row_max <= '0;
    end else begin
      max_valid <= 1'b0;
      if (tmax_v && (state == FEED || state == DRAIN)) begin
        row_max <= $signed(tmax) > $signed(row_max) ? tmax : row_max;
        ret <= ret + 1'b1;
      end
      if (acc) iss <= iss + 1'b1;
      case (state)
        IDLE: if (io.start && io.row_len != '0) begin
          state <= FEED;
          cnum <= LEN_W'(io.row_len >> S) + LEN_W'(io.row_len[S-1:0] != '0);
          rem <= io.row_len[S-1:0];
          iss <= '0;
          ret <= '0;
          row_max <= 16'h8000;
          busy <= 1'b1;
          in_ready <= 1'b1;
        end
        FEED: if (acc && last) begin
          state <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: if (tmax_v && ret + 1'b1 == cnum) begin
          state <= DONE;
          max_valid <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
  assign io.busy = busy;
  assign io.in_ready = in_ready;
  assign io.max_valid = max_valid;
  assign io.row_max = row_max;
`ifdef MAX_TREE_CTRL_BYPASS_EN
  // real-element mask travels alongside the tree so bubbles and padding read 0
  logic [N-1:0] mk [0:S];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) mk[k] <= '0;
    end else begin
      mk[0] <= {N{acc}} & ~pad;
      for (int k = 1; k <= S; k++) mk[k] <= mk[k-1];
    end
  end
  assign io.byp_valid = mk[S];
`endif
endmodule

// File: tb/tb_max_tree_ctrl.sv
// tb_max_tree_ctrl: scoreboard bench for max_tree_ctrl with a plain-arithmetic row-max model.
module tb_max_tree_ctrl;
  localparam int N = 8, LEN_W = 10, S = $clog2(N);
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, total = 0, bad = 0;
  typedef struct { logic [15:0] mx; int t; } exp_t;
  typedef struct { logic [N-1:0] m; logic [N*16-1:0] d; int t; } byp_t;
  exp_t eq[$];
  byp_t bq[$];
  exp_t eh;
  byp_t bh;
  max_tree_ctrl_if #(.N(N), .LEN_W(LEN_W)) io ();
  max_tree_ctrl #(.N(N), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [N*16-1:0] act, input logic [N*16-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (!rst && io.max_valid) begin
    if (eq.size() == 0) check("spurious_max_valid", io.max_valid, 1'b0);
    else begin
      eh = eq.pop_front();
      check("row_max", io.row_max, eh.mx);
      check("max_valid_cycle", cyc, eh.t);
      check("busy_at_max_valid", io.busy, 1'b1);
    end
  end

`ifdef MAX_TREE_CTRL_BYPASS_EN
  always @(negedge clk) if (!rst) begin
    if (bq.size() != 0 && bq[0].t == cyc) begin
      bh = bq.pop_front();
      check("byp_valid", io.byp_valid, bh.m);
      check("byp_data", io.byp_data, bh.d);
    end else if (io.byp_valid != '0) check("byp_valid_idle", io.byp_valid, '0);
  end
`endif

  // mode: 0 random, 1 fixed lanes, 2 negatives with 0x0400 at element 17, 3 all 0xF000
  // bub: 0 none, 1 toggle, 2 random; ign pulses start mid-row; abort resets in DRAIN
  task automatic run_row(input int len, input int mode, input int bub, input bit ign, input bit abort);
    logic [15:0] el[$];
    int fixed[8] = '{1, -3, 7, 2, 0, -8, 5, 4};
    int c, k, g, m, acc_e, w;
    byp_t b;
    c = (len + N - 1) / N;
    m = -32768;
    for (int i = 0; i < c * N; i++) begin
      if (i >= len) el.push_back(16'($urandom_range(16'h4000, 16'h7FFF)));
      else if (mode == 1) el.push_back(16'(fixed[i % 8] * 1024));
      else if (mode == 2) el.push_back(i == 17 ? 16'h0400 : 16'(16'h8000 + $urandom_range(0, 16'h7FFF)));
      else if (mode == 3) el.push_back(16'hF000);
      else el.push_back(16'($urandom_range(0, 16'hFFFF)));
      if (i < len && $signed(el[i]) > m) m = $signed(el[i]);
    end
    io.start = 1'b1;
    io.row_len = LEN_W'(len);
    @(posedge clk); #1;
    io.start = 1'b0;
    k = 0; g = 0; acc_e = 0;
    while (k < c && g < 4 * c + 20) begin
      io.in_valid = bub == 0 ? 1'b1 : bub == 1 ? 1'(g % 2 == 0) : 1'($urandom_range(0, 1));
      io.start = ign && g == 1;
      io.row_len = ign && g == 1 ? LEN_W'(5) : LEN_W'(len);
      for (int i = 0; i < N; i++) io.in_data[i*16+:16] = el[k*N+i];
      @(negedge clk);
      if (g == 0) check("busy_after_start", io.busy, 1'b1);
      if (io.in_valid && io.in_ready) begin
        acc_e = cyc + 1;
        for (int i = 0; i < N; i++) b.m[i] = k * N + i < len;
        b.d = io.in_data;
        b.t = acc_e + S;
        bq.push_back(b);
        k++;
      end
      @(posedge clk); #1;
      g++;
    end
    io.in_valid = 1'b0;
    io.start = 1'b0;
    check("chunks_accepted", k, c);
    if (abort) begin
      @(negedge clk); #1;
      rst = 1'b1;
      bq.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", io.busy, 1'b0);
      check("abort_row_max", io.row_max, 16'h0000);
      repeat (10) @(posedge clk);
      #1;
    end else begin
      eh.mx = 16'(m);
      eh.t = acc_e + S + 1;
      eq.push_back(eh);
      w = 0;
      while (eq.size() != 0 && w < 200) begin @(posedge clk); w++; end
      check("row_done_timeout", eq.size(), 0);
      eq.delete();
      @(posedge clk); #1;
      check("busy_after_row", io.busy, 1'b0);
    end
  endtask

  initial begin
    io.start = 1'b0;
    io.row_len = '0;
    io.in_valid = 1'b0;
    io.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", io.busy, 1'b0);
    check("rst_in_ready", io.in_ready, 1'b0);
    check("rst_max_valid", io.max_valid, 1'b0);
    check("rst_row_max", io.row_max, 16'h0000);
`ifdef MAX_TREE_CTRL_BYPASS_EN
    check("rst_byp_valid", io.byp_valid, '0);
    check("rst_byp_data", io.byp_data, '0);
`endif
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_row(8, 1, 0, 0, 0);
    run_row(19, 2, 0, 0, 0);
    run_row(19, 3, 0, 0, 0);
    run_row(24, 0, 1, 0, 0);
    io.start = 1'b1;
    io.row_len = '0;
    @(posedge clk); #1;
    io.start = 1'b0;
    @(negedge clk);
    check("len0_busy", io.busy, 1'b0);
    check("len0_in_ready", io.in_ready, 1'b0);
    @(posedge clk); #1;
    run_row(19, 0, 0, 1, 0);
    run_row(24, 0, 0, 0, 1);
    run_row(19, 2, 1, 0, 0);
    run_row(1, 0, 0, 0, 0);
    run_row(1023, 0, 0, 0, 0);
    for (int r = 0; r < 12; r++) run_row($urandom_range(1, 70), 0, $urandom_range(0, 2), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
